uart_res_serializer: RTL and testbench

- Upstream feeder for the master-control UART source mux; drives the result-side byte and transmit-start inputs of that mux.
- On a dump request it reads N_WORDS correlator result words from the result RAM and emits one header byte. It then emits each word as WORD_W/8 bytes, MSB first, pacing every byte on the UART transmitter's busy flag.
- It owns the mux select for the duration of a dump.

---
 rtl/uart_res_serializer.sv | 120 ++++++++++++
 tb/tb_uart_res_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_res_serializer.sv
// rtl/uart_res_serializer.sv - streams a header plus N_WORDS result-RAM words, MSB byte first, to the UART mux
module uart_res_serializer #(
    parameter int         WORD_W      = 32,
    parameter int         N_WORDS     = 1024,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_data,
    input  logic              TxD_busy,
    output logic              uart_src_sel,
    output logic              start_uart_tx_res,
    output logic [7:0]        res_byte,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int BYTES = WORD_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, ARM, SEND, WAIT_HI, WAIT_LO, RD, LOAD, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic                hdr_q, hdr_d;
    logic                hi_q, hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            hdr_q   <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            hdr_q   <= hdr_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        hdr_d   = hdr_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = ARM;
                    hdr_d   = 1'b1;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                end
            end
            ARM: begin
                if (!TxD_busy) state_d = SEND;
            end
            SEND: begin
                hi_d    = 1'b0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // Guard: a transmitter that never reports busy must not stall the dump.
                if (TxD_busy || hi_q) state_d = WAIT_LO;
                else                  hi_d    = 1'b1;
            end
            WAIT_LO: begin
                if (!TxD_busy) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = RD;
                    end else if (bcnt_q < LAST_BYTE) begin
                        word_d  = word_q << 8;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = SEND;
                    end else if (wcnt_q < LAST_WORD) begin
                        wcnt_d  = wcnt_q + 1'b1;
                        state_d = RD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD:   state_d = LOAD;
            LOAD: begin
                word_d  = ram_data;
                bcnt_d  = '0;
                state_d = SEND;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ram_rd_en         = (state_q == RD);
    assign ram_addr          = wcnt_q;
    assign start_uart_tx_res = (state_q == SEND);
    assign dump_done         = (state_q == FIN);
    assign dump_busy         = (state_q != IDLE) && (state_q != FIN);
    assign uart_src_sel      = dump_busy;
    assign res_byte          = hdr_q ? HEADER_BYTE : word_q[WORD_W-1 -: 8];

endmodule

// File: tb/tb_uart_res_serializer.sv
// tb/tb_uart_res_serializer.sv - randomized self-checking bench for uart_res_serializer
module tb_uart_res_serializer;

    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dump_start = 1'b0;
    logic        ram_rd_en;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data = '0;
    logic        TxD_busy;
    logic        uart_src_sel;
    logic        start_uart_tx_res;
    logic [7:0]  res_byte;
    logic        dump_busy;
    logic        dump_done;

    uart_res_serializer #(.WORD_W(32), .N_WORDS(NW), .ADDR_W(10), .HEADER_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .dump_start(dump_start),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data(ram_data),
        .TxD_busy(TxD_busy), .uart_src_sel(uart_src_sel),
        .start_uart_tx_res(start_uart_tx_res), .res_byte(res_byte),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result RAM: data valid only in the cycle after a read, noise otherwise.
    logic [31:0] mem [NW];
    always @(posedge clk) ram_data <= ram_rd_en ? mem[ram_addr[0]] : $urandom();

    // UART model: busy for busy_len cycles after each start, or forced high.
    int   ucnt = 0;
    int   busy_len = 10;
    logic force_busy = 1'b0;
    assign TxD_busy = force_busy | (ucnt > 0);
    always @(posedge clk) begin
        if (start_uart_tx_res && busy_len > 0) ucnt <= busy_len;
        else if (ucnt > 0)                     ucnt <= ucnt - 1;
    end

    logic [7:0] got_q[$];
    int         pulse_cyc[$];
    int         rd_q[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (start_uart_tx_res) begin
                got_q.push_back(res_byte);
                pulse_cyc.push_back(cyc);
                chk("sel_at_start", 32'(uart_src_sel), 32'd1);
            end
            if (ram_rd_en) rd_q.push_back(int'(ram_addr));
            if (dump_done) begin
                done_cnt++;
                chk("sel_at_done", 32'(uart_src_sel), 32'd0);
                chk("busy_at_done", 32'(dump_busy), 32'd0);
                chk("uart_idle_at_done", 32'(TxD_busy), 32'd0);
            end
        end
    end

    task automatic clear_log();
        got_q.delete();
        pulse_cyc.delete();
        rd_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk) dump_start = 1'b1;
        repeat (len) @(negedge clk);
        dump_start = 1'b0;
        chk("sel_after_start", 32'(uart_src_sel), 32'd1);
        chk("busy_after_start", 32'(dump_busy), 32'd1);
    endtask

    task automatic wait_done(input int max_cyc, input bit poke_fin);
        int n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("dump_timeout", 32'(done_cnt > 0), 32'd1);
        if (poke_fin && dump_done) begin
            dump_start = 1'b1;
            @(negedge clk) dump_start = 1'b0;
        end
        repeat (200) @(negedge clk);
    endtask

    // Reference: header then every word MSB byte first; one read per word in order.
    task automatic check_dump(input string tag);
        logic [7:0] exp_b[$];
        exp_b.push_back(8'hA5);
        for (int w = 0; w < NW; w++)
            for (int b = 3; b >= 0; b--)
                exp_b.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_b[i]));
        chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(NW));
        for (int i = 0; i < rd_q.size() && i < NW; i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(rd_q[i]), 32'(i));
        chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        #2;
        chk("rst_sel", 32'(uart_src_sel), 32'd0);
        chk("rst_start", 32'(start_uart_tx_res), 32'd0);
        chk("rst_byte", 32'(res_byte), 32'd0);
        chk("rst_rd", 32'(ram_rd_en), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed frame from the reference vectors
        clear_log();
        pulse_start(1);
        wait_done(2000, 1'b0);
        check_dump("fixed");

        // Randomized contents and UART busy time; dump_start poked in FIN cycle
        for (int t = 0; t < 4; t++) begin
            mem[0] = $urandom();
            mem[1] = $urandom();
            busy_len = $urandom_range(3, 14);
            clear_log();
            pulse_start(1);
            wait_done(2000, 1'b1);
            check_dump($sformatf("rand%0d", t));
        end

        // Transmitter busy at the request stalls before the header
        mem[0] = $urandom();
        mem[1] = $urandom();
        busy_len = 10;
        clear_log();
        force_busy = 1'b1;
        pulse_start(1);
        repeat (30) @(negedge clk);
        chk("stall_no_pulse", 32'(got_q.size()), 32'd0);
        chk("stall_sel", 32'(uart_src_sel), 32'd1);
        force_busy = 1'b0;
        wait_done(2000, 1'b0);
        check_dump("stall");

        // Held start plus a mid-dump pulse: still exactly one dump
        clear_log();
        pulse_start(5);
        repeat (40) @(negedge clk);
        dump_start = 1'b1;
        @(negedge clk) dump_start = 1'b0;
        wait_done(2000, 1'b0);
        check_dump("held");

        // Transmitter never asserts busy: guard keeps it moving
        busy_len = 0;
        clear_log();
        pulse_start(1);
        wait_done(2000, 1'b0);
        check_dump("nobusy");
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk($sformatf("spacing%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1] >= 3), 32'd1);

        // Reset partway through the third byte's wait
        busy_len = 10;
        clear_log();
        pulse_start(1);
        begin
            int n = 0;
            while (got_q.size() < 3 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("rst_mid_reach", 32'(got_q.size() >= 3), 32'd1);
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(uart_src_sel), 32'd0);
        chk("mid_rst_start", 32'(start_uart_tx_res), 32'd0);
        chk("mid_rst_byte", 32'(res_byte), 32'd0);
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_busy", 32'(dump_busy), 32'd0);
        chk("mid_rst_done", 32'(dump_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", 32'(done_cnt), 32'd0);
        mem[0] = $urandom();
        mem[1] = $urandom();
        clear_log();
        pulse_start(1);
        wait_done(2000, 1'b0);
        check_dump("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
